// File: rtl/arm7tdmi_pkg.sv
// Shared types for the ARM7TDMI halfword/signed-byte load-store unit.
package arm7tdmi_pkg;

  typedef enum logic [1:0] {
    STRH  = 2'd0,
    LDRH  = 2'd1,
    LDRSB = 2'd2,
    LDRSH = 2'd3
  } hw_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WB   = 2'd2
  } hw_lsu_state_t;

  // Every op except STRH returns data to the register file.
  function automatic logic is_load(hw_op_t op);
    return op != STRH;
  endfunction

  // LDRSB is the only byte access; all other ops move a halfword.
  function automatic logic is_halfword(hw_op_t op);
    return op != LDRSB;
  endfunction

endpackage

// File: rtl/arm7tdmi_hw_extend.sv
// Load data lane selection and zero/sign extension for halfword and signed-byte loads.
module arm7tdmi_hw_extend
  import arm7tdmi_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  hw_op_t      hw_op,
  output logic [31:0] result
);

  logic signed [15:0] half_sel;
  logic signed [7:0]  byte_sel;

  // Pick the addressed lane and extend it according to the op.
  always_comb begin
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    case (addr)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    result = '0;
    case (hw_op)
      LDRH:    result = {16'd0, half_sel};
      LDRSH:   result = {{16{half_sel[15]}}, half_sel};
      LDRSB:   result = {{24{byte_sel[7]}}, byte_sel};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/arm7tdmi_halfword_lsu.sv
// ARM7TDMI halfword / signed-byte load-store unit (STRH, LDRH, LDRSB, LDRSH).
// Optional feature macro ARM7TDMI_HW_ALIGN_FAULT_EN: when defined, an odd-address
// halfword op faults (no memory access, no writeback); otherwise the address is
// silently halfword-aligned.
module arm7tdmi_halfword_lsu
  import arm7tdmi_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        hw_op,
  input  logic              pre,
  input  logic              up,
  input  logic              wb,
  input  logic              imm_en,
  input  logic [7:0]        imm8,
  input  logic [31:0]       rn_data,
  input  logic [31:0]       rm_data,
  input  logic [31:0]       rd_data,
  input  logic [3:0]        rn_idx,
  input  logic [3:0]        rd_idx,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              mem_we,
  output logic              mem_re,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       rd_wdata,
  output logic [31:0]       rn_wdata,
  output logic              rd_we,
  output logic              rn_we,
  output logic [3:0]        wr_idx_rd,
  output logic [3:0]        wr_idx_rn,
  output logic              busy,
  output logic              done,
  output logic              align_fault
);

  hw_lsu_state_t state, state_nxt;
  hw_op_t        op_p0, op_p1;
  logic [31:0]   offset_p0, eff_p0, addr_raw_p0, addr_p0;
  logic [31:0]   eff_p1, addr_p1, ld_p2, ext_result;
  logic [15:0]   st_half_p1;
  logic [3:0]    rn_idx_p1, rd_idx_p1;
  logic          wb_cond_p1;
  logic          fault_go, fault_w;
  logic          unused_rd_hi;

  assign op_p0        = hw_op_t'(hw_op);
  assign unused_rd_hi = ^rd_data[31:16];

  // Address generation from the live command inputs.
  always_comb begin
    offset_p0   = imm_en ? {24'd0, imm8} : rm_data;
    eff_p0      = up ? (rn_data + offset_p0) : (rn_data - offset_p0);
    addr_raw_p0 = pre ? eff_p0 : rn_data;
    addr_p0     = addr_raw_p0;
`ifndef ARM7TDMI_HW_ALIGN_FAULT_EN
    if (is_halfword(op_p0)) addr_p0[0] = 1'b0;
`endif
  end

`ifdef ARM7TDMI_HW_ALIGN_FAULT_EN
  logic fault_p1;
  assign fault_go = is_halfword(op_p0) && addr_raw_p0[0];
  assign fault_w  = fault_p1;

  // Remember whether the accepted command faulted on alignment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          fault_p1 <= 1'b0;
    else if (state == IDLE && start)  fault_p1 <= fault_go;
  end
`else
  assign fault_go = 1'b0;
  assign fault_w  = 1'b0;
`endif

  // ---- p0 -> p1: command capture on acceptance ----
  // Command fields are only observed through state-gated outputs, so they carry no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      op_p1      <= op_p0;
      eff_p1     <= eff_p0;
      addr_p1    <= addr_p0;
      st_half_p1 <= rd_data[15:0];
      rn_idx_p1  <= rn_idx;
      rd_idx_p1  <= rd_idx;
      wb_cond_p1 <= !pre || wb;
    end
  end

  arm7tdmi_hw_extend u_extend (
    .rdata  (mem_rdata),
    .addr   (addr_p1[1:0]),
    .hw_op  (op_p1),
    .result (ext_result)
  );

  // ---- p1 -> p2: load data capture in the accepted memory cycle ----
  always_ff @(posedge clk) begin
    if (state == REQ && mem_ready && is_load(op_p1)) ld_p2 <= ext_result;
  end

  // State register; asynchronous reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and all outputs, decoded from state so idle/reset drives zeros.
  always_comb begin
    state_nxt   = state;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_be      = '0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    rd_wdata    = '0;
    rn_wdata    = '0;
    rd_we       = 1'b0;
    rn_we       = 1'b0;
    wr_idx_rd   = '0;
    wr_idx_rn   = '0;
    done        = 1'b0;
    align_fault = 1'b0;
    busy        = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) state_nxt = fault_go ? WB : REQ;
      end
      REQ: begin
        mem_addr = addr_p1[ADDR_W-1:0];
        if (is_load(op_p1)) begin
          mem_re = 1'b1;
          mem_be = 4'b1111;
        end else begin
          mem_we    = 1'b1;
          mem_wdata = {st_half_p1, st_half_p1};
          mem_be    = addr_p1[1] ? 4'b1100 : 4'b0011;
        end
        if (mem_ready) state_nxt = WB;
      end
      WB: begin
        done        = 1'b1;
        align_fault = fault_w;
        if (is_load(op_p1) && !fault_w) begin
          rd_we     = 1'b1;
          rd_wdata  = ld_p2;
          wr_idx_rd = rd_idx_p1;
        end
        // A load targeting the base register takes priority over base writeback.
        if (wb_cond_p1 && !fault_w && !(is_load(op_p1) && rd_idx_p1 == rn_idx_p1)) begin
          rn_we     = 1'b1;
          rn_wdata  = eff_p1;
          wr_idx_rn = rn_idx_p1;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/arm7tdmi_halfword_lsu.md
ARM7TDMI_HALFWORD_LSU -- requirements
Module: arm7tdmi_halfword_lsu

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, the memory address width in bits.
REQ-002 The block SHALL have these ports:
- clk  in  1  the single clock.
- rst  in  1  reset; asynchronous, active-high.
REQ-003 The block SHALL have these command ports:
- start  in  1  command valid.
- hw_op  in  2  operation: STRH, LDRH, LDRSB, LDRSH.
- pre, up, wb  in  1 each  addressing flags.
- imm_en  in  1  offset source select.
- imm8  in  8  immediate offset, {instr[11:8], instr[3:0]}.
- rn_data, rm_data, rd_data  in  32 each  base, register offset and store data.
- rn_idx, rd_idx  in  4 each  register indices.
REQ-004 The block SHALL have these memory ports:
- mem_addr  out  ADDR_W
- mem_wdata  out  32
- mem_be  out  4
- mem_we, mem_re  out  1 each
- mem_ready  in  1
- mem_rdata  in  32
REQ-005 The block SHALL have these result ports:
- rd_wdata, rn_wdata  out  32 each
- rd_we, rn_we  out  1 each
- wr_idx_rd, wr_idx_rn  out  4 each
- busy, done  out  1 each
- align_fault  out  1

Function
REQ-006 The FSM SHALL have states IDLE, REQ and WB, held in a registered state vector.
REQ-007 In IDLE, start=1 SHALL capture all command inputs and move to REQ; start is ignored in every state other than IDLE.
REQ-008 offset SHALL be imm_en ? zero-extended imm8 : rm_data.
REQ-009 eff = rn_data +/- offset, using + when up=1 and modulo-2^32 wrap-around.
REQ-010 mem_addr SHALL be eff when pre=1, otherwise rn_data.
REQ-011 In REQ, mem_re (loads) or mem_we (STRH) SHALL be asserted, with mem_addr, mem_wdata and mem_be held stable until a cycle with mem_ready=1; the FSM then moves to WB.
REQ-012 STRH SHALL drive mem_wdata = {rd_data[15:0], rd_data[15:0]}, with mem_be = 4'b0011 when addr[1]=0 and 4'b1100 otherwise.
REQ-013 Loads SHALL drive mem_be = 4'b1111 and capture mem_rdata in the mem_ready cycle.
REQ-014 LDRH SHALL zero-extend the halfword selected by addr[1].
REQ-015 LDRSH SHALL sign-extend the halfword selected by addr[1].
REQ-016 LDRSB SHALL sign-extend the byte selected by addr[1:0].
REQ-017 The WB state SHALL last exactly one cycle, assert done=1, and return to IDLE.
REQ-018 In WB, loads SHALL assert rd_we=1 with rd_wdata and wr_idx_rd.
REQ-019 In WB, base writeback SHALL be performed when (pre=0) or (wb=1): rn_we=1, rn_wdata=eff, wr_idx_rn=rn_idx.
REQ-020 For a load with rd_idx==rn_idx, the load SHALL win: rn_we=0.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 With mem_ready held at 1, latency from start to done SHALL be 2 cycles, and a new start SHALL be accepted on the cycle after done.
REQ-023 mem_re, mem_we, rd_we, rn_we and done SHALL be 0 in every state other than the one that asserts them.

Reset
REQ-024 While rst=1 (asynchronous), the block SHALL be in IDLE with every output 0, including mem_be=0 and align_fault=0.
REQ-025 A reset asserted in REQ or WB SHALL abort the operation with no writeback and no further memory strobe.

Configuration
REQ-026 Macro ARM7TDMI_HW_ALIGN_FAULT_EN SHALL control odd-address halfword handling.
REQ-027 With ARM7TDMI_HW_ALIGN_FAULT_EN defined, a halfword op (not LDRSB) with addr[0]=1 SHALL go from IDLE directly to WB with no memory strobe, assert align_fault=1 for that cycle, and suppress rd_we and rn_we.
REQ-028 Without ARM7TDMI_HW_ALIGN_FAULT_EN, addr[0] SHALL be forced to 0 for halfword ops and align_fault SHALL be tied to 0.

Structure
REQ-029 hw_op_t (STRH=0, LDRH=1, LDRSB=2, LDRSH=3) and hw_lsu_state_t SHALL be declared in arm7tdmi_pkg.
REQ-030 Load alignment and extension SHALL be a combinational sub-module, arm7tdmi_hw_extend, with inputs rdata, addr[1:0] and hw_op, and output a 32-bit result.

Verification
REQ-031 Case: STRH, rn=0x2000, imm8=4, pre=1, up=1, rd_data=0x1234DEAD. Required: mem_addr=0x2004, be=0011, wdata=0xDEADDEAD, no rn_we.
REQ-032 Case: LDRSB, rn=0x2010, imm8=2, mem_rdata=0x007F8000. Required: rd_wdata=0x0000007F.
REQ-033 Case: LDRSH, addr=0x2022, mem_rdata=0x80001234. Required: rd_wdata=0xFFFF8000.
REQ-034 Case: LDRH post-index, rn=0x2000, rm=8, up=0, with mem_ready low for 3 cycles. Required: strobes held 3 extra cycles, then rn_wdata=0x1FF8, rd_we=1 and done=1 in the same cycle.
REQ-035 Case: LDRH with rd_idx==rn_idx=1 and wb=1. Required: rd_we=1, rn_we=0.
REQ-036 Case: LDRH at 0x2001 with the macro defined. Required: align_fault=1, no mem_re. Without the macro, mem_addr=0x2000.
